// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'd1;
            SIZE_H:  return 4'd2;
            SIZE_W:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte storage split into 8 byte lanes (lane = addr[2:0]), each with its own
// row address so a misaligned access can straddle two 8-byte rows.
module dmem_byte_array #(
    parameter int unsigned ROWS  = 128,
    parameter int unsigned ROW_W = 7
) (
    input  logic                  clock,
    input  logic [7:0]            we,
    input  logic [7:0][ROW_W-1:0] row,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);

    for (genvar l = 0; l < 8; l++) begin : g_lane
        logic [7:0] mem [ROWS];

        always_ff @(posedge clock) begin
            if (we[l]) begin
                mem[row[l]] <= wdata[8*l +: 8];
            end
        end

        assign rdata[8*l +: 8] = mem[row[l]];
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with sized, misaligned little-endian access,
// bounds fault reporting, optional wait states and a clear-on-reset pass.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              init_done
);

    localparam int unsigned   ROWS      = DEPTH_BYTES / 8;
    localparam int unsigned   ROW_W     = $clog2(ROWS);
    localparam logic [3:0]    WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0] END_LIMIT = (ADDR_W+1)'(DEPTH_BYTES);

    state_t             state;
    logic [ROW_W-1:0]   clr_ptr;
    logic [3:0]         wait_cnt;
    logic               r_write;
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_addr;
    logic [63:0]        r_wdata;

    logic               use_in;
    logic               s_write;
    logic [1:0]         s_size;
    logic [ADDR_W-1:0]  s_addr;
    logic [63:0]        s_wdata;
    logic [3:0]         nbytes;
    logic [ADDR_W:0]    end_addr;
    logic               fault;
    logic               commit;
    logic [2:0]         off;
    logic [2:0]         k;
    logic [ROW_W-1:0]   base_row;
    logic [7:0]         lane_en;
    logic [7:0]         arr_we;
    logic [7:0][ROW_W-1:0] arr_row;
    logic [63:0]        arr_wdata;
    logic [63:0]        arr_rdata;
    logic [127:0]       wdbl;
    logic [127:0]       rdbl;
    logic [63:0]        load_data;
    logic [63:0]        size_mask;

    // With no wait states the store commits on the accept edge itself, so the
    // access is taken straight from the request inputs while idle.
    always_comb begin
        use_in   = (state == ST_IDLE);
        s_write  = use_in ? req_write : r_write;
        s_size   = use_in ? req_size  : r_size;
        s_addr   = use_in ? req_addr  : r_addr;
        s_wdata  = use_in ? req_wdata : r_wdata;
        nbytes   = size_to_nbytes(s_size);
        end_addr = {1'b0, s_addr} + (ADDR_W+1)'(nbytes);
        fault    = (end_addr > END_LIMIT);
        commit   = (WAIT_CYCLES == 0) ? (use_in && req_valid)
                                      : ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));
        off      = s_addr[2:0];
        base_row = s_addr[ROW_W+2:3];
        k        = '0;
        lane_en  = '0;
        arr_row  = '0;
        for (int unsigned l = 0; l < 8; l++) begin
            k          = 3'(l) - off;
            lane_en[l] = ({1'b0, k} < nbytes);
            arr_row[l] = base_row + ROW_W'(3'(l) < off);
        end

        wdbl      = {s_wdata, s_wdata};
        rdbl      = {arr_rdata, arr_rdata};
        load_data = rdbl[8*int'(off) +: 64];
        case (s_size)
            SIZE_B:  size_mask = 64'h0000_0000_0000_00FF;
            SIZE_H:  size_mask = 64'h0000_0000_0000_FFFF;
            SIZE_W:  size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase

        if (state == ST_INIT) begin
            arr_we    = '1;
            arr_wdata = '0;
            for (int unsigned l = 0; l < 8; l++) begin
                arr_row[l] = clr_ptr;
            end
        end else begin
            arr_we    = (commit && s_write && !fault) ? lane_en : '0;
            arr_wdata = wdbl[64 - 8*int'(off) +: 64];
        end
    end

    dmem_byte_array #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .row   (arr_row),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            clr_ptr   <= '0;
            wait_cnt  <= '0;
            r_write   <= 1'b0;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ROW_W'(ROWS - 1)) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write   <= req_write;
                        r_size    <= req_size;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_error <= fault;
                    rsp_rdata <= (!r_write && !fault) ? (load_data & size_mask) : '0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
